// File: rtl/cordic_sweep_bist_if.sv
// Connection bundle between the sweep BIST and the CORDIC pipeline core.
// master = BIST side (drives core inputs), slave = core side.
interface cordic_sweep_bist_if #(
  parameter int WIDTH           = 16,
  parameter int FLIP_FLAG_WIDTH = 2
);
  logic [WIDTH-1:0]           degree_in;
  logic [WIDTH-1:0]           x_in;
  logic [WIDTH-1:0]           y_in;
  logic [FLIP_FLAG_WIDTH-1:0] sector_in;
  logic                       arctan_en_in;
  logic [WIDTH-1:0]           degree_out;
  logic [WIDTH-1:0]           x_out;
  logic [WIDTH-1:0]           y_out;

  modport master (
    output degree_in, x_in, y_in, sector_in, arctan_en_in,
    input  degree_out, x_out, y_out
  );

  modport slave (
    input  degree_in, x_in, y_in, sector_in, arctan_en_in,
    output degree_out, x_out, y_out
  );
endinterface

// File: rtl/cordic_sweep_bist.sv
// Self-checking angle-sweep stimulus engine for the CORDIC pipeline core.
// Issues one angle per cycle, tracks each through a latency-matched tag pipe,
// and checks magnitude and residual angle of every returned result.
module cordic_sweep_bist #(
  parameter int               WIDTH           = 16,
  parameter int               FRAC_WIDTH      = 8,
  parameter int               PIPE_LATENCY    = 8,
  parameter int               FLIP_FLAG_WIDTH = 2,
  parameter logic [WIDTH-1:0] ANGLE_MIN       = 16'h0000,
  parameter logic [WIDTH-1:0] ANGLE_MAX       = 16'h0400,
  parameter logic [WIDTH-1:0] ANGLE_STEP      = 16'h0100,
  parameter logic [WIDTH-1:0] X_INIT          = 16'h0100,
  parameter logic [WIDTH-1:0] Y_INIT          = 16'h0000,
  parameter int               MAG_EXPECT      = 1 << (2 * FRAC_WIDTH),
  parameter int               MAG_TOL         = 1024,
  parameter int               ANGLE_TOL       = 4,
  parameter int               CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [WIDTH-1:0]     first_err_angle,
  cordic_sweep_bist_if.master  core
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_e;

  localparam int DW = $clog2(PIPE_LATENCY + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);
  localparam logic signed [2*WIDTH+1:0] MAG_EXP_W = (2*WIDTH+2)'(MAG_EXPECT);
  localparam logic signed [2*WIDTH+1:0] MAG_TOL_W = (2*WIDTH+2)'(MAG_TOL);
  localparam logic signed [WIDTH:0]     ANG_TOL_W = (WIDTH+1)'(ANGLE_TOL);

  state_e                            state_q, state_d;
  logic [WIDTH-1:0]                  angle_q, angle_d;
  logic                              cont_q, cont_d;
  logic [DW-1:0]                     drain_q, drain_d;
  logic [PIPE_LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [PIPE_LATENCY-1:0][WIDTH-1:0] tag_ang_q, tag_ang_d;
  logic [CNT_WIDTH-1:0]              err_q, err_d, smp_q, smp_d;
  logic [WIDTH-1:0]                  ferr_q, ferr_d;
  logic                              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic                              issue;
  logic signed [WIDTH:0]             nxt_ang;
  logic                              last;
  logic signed [2*WIDTH-1:0]         xsq, ysq;
  logic signed [2*WIDTH:0]           mag;
  logic signed [2*WIDTH+1:0]         mag_diff, mag_abs;
  logic signed [WIDTH:0]             deg_ext, deg_abs;
  logic                              sample_bad;

  assign core.degree_in    = angle_q;
  assign core.x_in         = X_INIT;
  assign core.y_in         = Y_INIT;
  assign core.sector_in    = '0;
  assign core.arctan_en_in = 1'b0;

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign sample_count    = smp_q;
  assign first_err_angle = ferr_q;

  // Result checker: magnitude window and residual angle window on the core output.
  always_comb begin
    xsq        = $signed(core.x_out) * $signed(core.x_out);
    ysq        = $signed(core.y_out) * $signed(core.y_out);
    mag        = $signed({xsq[2*WIDTH-1], xsq}) + $signed({ysq[2*WIDTH-1], ysq});
    mag_diff   = $signed({mag[2*WIDTH], mag}) - MAG_EXP_W;
    mag_abs    = (mag_diff < 0) ? -mag_diff : mag_diff;
    deg_ext    = $signed({core.degree_out[WIDTH-1], core.degree_out});
    deg_abs    = (deg_ext < 0) ? -deg_ext : deg_ext;
    sample_bad = (mag_abs > MAG_TOL_W) || (deg_abs > ANG_TOL_W);
  end

  // Next angle in WIDTH+1 bits so a step past the top never wraps into range.
  always_comb begin
    nxt_ang = $signed({angle_q[WIDTH-1], angle_q}) + $signed({1'b0, ANGLE_STEP});
    last    = nxt_ang > $signed({ANGLE_MAX[WIDTH-1], ANGLE_MAX});
  end

  // FSM next state, sweep control, result counters and tag pipe.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    cont_d  = cont_q;
    drain_d = drain_q;
    err_d   = err_q;
    smp_d   = smp_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    issue   = 1'b0;

    // Tail of the tag pipe lines up with the core output this cycle.
    if (tag_vld_q[PIPE_LATENCY-1]) begin
      if (smp_q != '1) smp_d = smp_q + 1'b1;
      if (sample_bad) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        if (err_q == '0) ferr_d = tag_ang_q[PIPE_LATENCY-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          angle_d = ANGLE_MIN;
          cont_d  = continuous;
          err_d   = '0;
          smp_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_SWEEP: begin
        issue = 1'b1;
        if (cont_q && stop) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (last) begin
          if (cont_q) begin
            angle_d = ANGLE_MIN;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          angle_d = nxt_ang[WIDTH-1:0];
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Final verdict is latched together with the last counter update.
    if (state_q == S_DRAIN && state_d == S_DONE) pass_d = (err_d == '0);

    busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);

    tag_vld_d[0] = issue;
    tag_ang_d[0] = angle_q;
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ang_d[i] = tag_ang_q[i-1];
    end
  end

  // State register with synchronous reset; reset also flushes the tag pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      angle_q   <= ANGLE_MIN;
      cont_q    <= 1'b0;
      drain_q   <= '0;
      tag_vld_q <= '0;
      tag_ang_q <= '0;
      err_q     <= '0;
      smp_q     <= '0;
      ferr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      cont_q    <= cont_d;
      drain_q   <= drain_d;
      tag_vld_q <= tag_vld_d;
      tag_ang_q <= tag_ang_d;
      err_q     <= err_d;
      smp_q     <= smp_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

endmodule

// File: doc/cordic_sweep_bist.md
# cordic_sweep_bist

Synthesizable self-checking stimulus engine for the CORDIC `pipeline` core, replacing the fixed-vector simulation bench with a parametrised sweep. It drives `pipeline` inputs with a programmable angle ramp and tracks each issued sample through a latency-matched tag pipe. It checks every returned result for vector magnitude and residual angle, then reports pass/fail, error count and the first failing angle. It sits beside `pipeline` in simulation and in FPGA bring-up builds.

## Interface

Parameters:
- `WIDTH` = 16: data width of angle and x/y words, signed Q(WIDTH-FRAC_WIDTH-1).FRAC_WIDTH.
- `FRAC_WIDTH` = 8: fractional bits.
- `PIPE_LATENCY` = 8: fixed `pipeline` latency in cycles, input to output; must be ≥1.
- `FLIP_FLAG_WIDTH` = 2: sector word width.
- `ANGLE_MIN` = 16'h0000, `ANGLE_MAX` = 16'h0400, `ANGLE_STEP` = 16'h0100: sweep range (signed) and step (>0).
- `X_INIT` = 16'h0100, `Y_INIT` = 16'h0000: constant x/y driven into the core.
- `MAG_EXPECT` = 65536: expected x²+y² in Q.(2·FRAC_WIDTH).
- `MAG_TOL` = 1024: allowed |x²+y² − MAG_EXPECT|.
- `ANGLE_TOL` = 4: allowed |degree_out| (residual angle, LSBs).
- `CNT_WIDTH` = 16: width of the count outputs.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `continuous` in 1: sampled at start; 1 = wrap the sweep until `stop`.
- `stop` in 1: in continuous mode, end issue after the current sample.
- `busy` out 1: run in progress (SWEEP or DRAIN).
- `done` out 1: one-cycle pulse when a run's last check completes.
- `pass` out 1: 1 if the last completed run had zero errors; holds until the next start.
- `err_count` out CNT_WIDTH: failing samples this run, saturating.
- `sample_count` out CNT_WIDTH: checked samples this run, saturating.
- `first_err_angle` out WIDTH: angle tag of the first failing sample; 0 if none.
- `degree_in`, `x_in`, `y_in` out WIDTH: drive to `pipeline`.
- `sector_in` out FLIP_FLAG_WIDTH: driven 0.
- `arctan_en_in` out 1: driven 0 (rotation mode).
- `degree_out`, `x_out`, `y_out` in WIDTH: from `pipeline`.

## Operation

- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE → SWEEP on `start`. The transition clears the counters, `first_err_angle` and `pass`, latches `continuous`, and loads the angle register with ANGLE_MIN.
- SWEEP: exactly one sample issued per cycle. The register drives `degree_in`. The issued angle and valid=1 enter a PIPE_LATENCY-deep tag shift register.
- Next angle: computed in WIDTH+1 bits as angle + ANGLE_STEP. If it exceeds ANGLE_MAX, the current sample is last, and the FSM goes to DRAIN, or reloads ANGLE_MIN when `continuous`=1 and `stop`=0. No overflow wrap is ever issued.
- Continuous mode with `stop`=1: the current cycle's sample is the last one issued, then the FSM goes to DRAIN.
- DRAIN: valid=0 enters the tag pipe. The FSM leaves after PIPE_LATENCY cycles, when the pipe is empty, and goes to DONE.
- DONE: one cycle; `done`=1, `pass` = (err_count==0), then IDLE.
- Check, every cycle the tag-pipe tail valid=1:
  - mag = x_out² + y_out², signed products, 2·WIDTH+1 bits.
  - Fail if |mag − MAG_EXPECT| > MAG_TOL or |degree_out| > ANGLE_TOL.
  - sample_count increments by 1.
  - On fail: err_count increments by 1. If this is the first fail, the tail angle is captured into `first_err_angle`.
  - Counters saturate at all-ones.
- `start` in any state other than IDLE is ignored. `stop` outside continuous SWEEP is ignored.
- Reset (any state, mid-run included): FSM→IDLE and tag pipe all valid=0 next edge. All outputs return to reset values; no `done` is emitted.
- Reset values: `busy`=0, `done`=0, `pass`=0, counts 0, `first_err_angle`=0, `degree_in`=ANGLE_MIN, `x_in`=X_INIT, `y_in`=Y_INIT, `sector_in`=0, `arctan_en_in`=0.

## Timing

- All outputs are registered.
- `start` high at edge t → SWEEP from t+1; first `degree_in`=ANGLE_MIN valid in cycle t+1.
- Sample issued in cycle c is checked in cycle c+PIPE_LATENCY. Counters update at the following edge.
- N samples: issue cycles t+1..t+N. Last check at t+N+PIPE_LATENCY. `done` and final `pass` appear at t+N+PIPE_LATENCY+1.
- `busy` is high from t+1 through t+N+PIPE_LATENCY, and low in the `done` cycle.
- Back-to-back runs: `start` is accepted in the first IDLE cycle after DONE.

## Test plan

- Ideal fixed-latency (8) model; defaults; start at cycle 0 → `degree_in` 0x0000, 0x0100, 0x0200, 0x0300, 0x0400 in cycles 1–5; `done` at cycle 14; sample_count 5, err_count 0, pass 1.
- Model adds 0x0040 to x_out for angle 0x0200 only → err_count 1, first_err_angle 0x0200, pass 0, sample_count 5.
- ANGLE_MAX=0x0300, ANGLE_STEP=0x0200 → only 0x0000 and 0x0200 issued; sample_count 2; `done` at cycle 11.
- Reset asserted in cycle 3 of SWEEP → next cycle busy 0, counts 0, no `done`. A fresh start then gives the full scenario-1 result.
- continuous=1, `stop` pulsed in the cycle 0x0100 is issued on the second lap → issue order 0x0000..0x0400, 0x0000, 0x0100; sample_count 7.
- `start` re-pulsed mid-SWEEP and mid-DRAIN → ignored; results identical to scenario 1.
